spi_dac_frame_receiver: RTL and testbench

- SPI slave that plays the DAC end of our 24-bit DAC command link (SPI mode 0, MSB first, CS_n framed).
- Decodes each complete frame into software-reset, LDAC-setup and channel-write commands, and holds four channel output registers.
- Used as the on-FPGA loopback and bench responder for the DAC sequencer. Also drives a PWM/R-2R output stage in the no-DAC build.

---
 rtl/spi_dac_pkg.sv | 27 ++
 rtl/spi_slave_shifter.sv | 91 +++++++++
 rtl/spi_dac_frame_receiver.sv | 143 ++++++++++++++
 tb/tb_spi_dac_frame_receiver.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/spi_dac_pkg.sv
// rtl/spi_dac_pkg.sv - frame layout, command codes and receiver state encoding
package spi_dac_pkg;

   localparam int FRAME_LEN = 24;

   localparam int CMD_HI  = 23;
   localparam int CMD_LO  = 20;
   localparam int ADDR_HI = 19;
   localparam int ADDR_LO = 16;
   localparam int DATA_HI = 15;
   localparam int DATA_LO = 0;

   localparam logic [3:0] CMD_UPDATE       = 4'h1;
   localparam logic [3:0] CMD_WRITE_INPUT  = 4'h2;
   localparam logic [3:0] CMD_WRITE_UPDATE = 4'h3;
   localparam logic [3:0] CMD_LDAC_SETUP   = 4'h6;
   localparam logic [3:0] CMD_SW_RESET     = 4'h7;

   localparam logic [3:0] ADDR_ALL = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DECODE
   } rx_state_t;

endpackage

// File: rtl/spi_slave_shifter.sv
// rtl/spi_slave_shifter.sv - SPI mode-0 input sync, edge detect, shifter and frame FSM
module spi_slave_shifter #(
   parameter int FRAME_LEN = spi_dac_pkg::FRAME_LEN,
   parameter int CNT_W     = $clog2(FRAME_LEN + 2)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 spi_sclk,
   input  logic                 spi_mosi,
   input  logic                 spi_cs_n,
   output logic                 frame_done,
   output logic [CNT_W-1:0]     bit_count,
   output logic [FRAME_LEN-1:0] shift_q
);
   import spi_dac_pkg::*;

   logic [1:0]           sclk_sync_q;
   logic [1:0]           mosi_sync_q;
   logic [1:0]           cs_sync_q;
   logic                 sclk_prev_q;
   logic                 cs_prev_q;
   logic                 armed_q;
   logic                 frame_done_q;
   logic [CNT_W-1:0]     bit_count_q;
   logic [FRAME_LEN-1:0] shift_reg_q;
   rx_state_t            state_q;

   logic sclk_rise;
   logic cs_rise;
   logic cs_fall;

   assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
   assign cs_rise   = cs_sync_q[1] & ~cs_prev_q;
   assign cs_fall   = ~cs_sync_q[1] & cs_prev_q;

   // armed only comes up once CS has been seen high, so a frame already in
   // flight at reset release is never mistaken for a fresh one
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync_q  <= '0;
         mosi_sync_q  <= '0;
         cs_sync_q    <= '0;
         sclk_prev_q  <= 1'b0;
         cs_prev_q    <= 1'b0;
         armed_q      <= 1'b0;
         frame_done_q <= 1'b0;
         bit_count_q  <= '0;
         shift_reg_q  <= '0;
         state_q      <= ST_IDLE;
      end else begin
         sclk_sync_q  <= {sclk_sync_q[0], spi_sclk};
         mosi_sync_q  <= {mosi_sync_q[0], spi_mosi};
         cs_sync_q    <= {cs_sync_q[0], spi_cs_n};
         sclk_prev_q  <= sclk_sync_q[1];
         cs_prev_q    <= cs_sync_q[1];
         frame_done_q <= 1'b0;
         if (cs_sync_q[1]) begin
            armed_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (cs_fall && armed_q) begin
                  bit_count_q <= '0;
                  shift_reg_q <= '0;
                  state_q     <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // CS rise wins over a coincident sclk edge
               if (cs_rise) begin
                  frame_done_q <= 1'b1;
                  state_q      <= ST_DECODE;
               end else if (sclk_rise) begin
                  shift_reg_q <= {shift_reg_q[FRAME_LEN-2:0], mosi_sync_q[1]};
                  if (bit_count_q != CNT_W'(FRAME_LEN + 1)) begin
                     bit_count_q <= bit_count_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign frame_done = frame_done_q;
   assign bit_count  = bit_count_q;
   assign shift_q    = shift_reg_q;

endmodule

// File: rtl/spi_dac_frame_receiver.sv
// rtl/spi_dac_frame_receiver.sv - DAC-side SPI frame decoder and channel register file
module spi_dac_frame_receiver #(
   parameter int FRAME_LEN = spi_dac_pkg::FRAME_LEN,
   parameter int DATA_W    = 12,
   parameter int NUM_CH    = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     spi_sclk,
   input  logic                     spi_mosi,
   input  logic                     spi_cs_n,
   output logic                     frame_valid,
   output logic [FRAME_LEN-1:0]     frame_data,
   output logic                     frame_err,
   output logic [NUM_CH-1:0]        ldac_mask,
   output logic [NUM_CH*DATA_W-1:0] dac_out,
   output logic [7:0]               err_count
);
   import spi_dac_pkg::*;

   localparam int CNT_W = $clog2(FRAME_LEN + 2);

   logic                 frame_done;
   logic [CNT_W-1:0]     bit_count;
   logic [FRAME_LEN-1:0] shift_q;

   spi_slave_shifter #(
      .FRAME_LEN(FRAME_LEN),
      .CNT_W    (CNT_W)
   ) u_shifter (
      .clk       (clk),
      .rst       (rst),
      .spi_sclk  (spi_sclk),
      .spi_mosi  (spi_mosi),
      .spi_cs_n  (spi_cs_n),
      .frame_done(frame_done),
      .bit_count (bit_count),
      .shift_q   (shift_q)
   );

   logic [3:0]        cmd;
   logic [3:0]        addr;
   logic [DATA_W-1:0] wdata;
   logic [NUM_CH-1:0] hit;

   assign cmd   = shift_q[CMD_HI:CMD_LO];
   assign addr  = shift_q[ADDR_HI:ADDR_LO];
   assign wdata = shift_q[DATA_HI -: DATA_W];

   // addresses NUM_CH..0xE select nothing
   always_comb begin
      hit = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         hit[ch] = (addr == ADDR_ALL) || (addr == 4'(ch));
      end
   end

   logic [DATA_W-1:0]    input_q [NUM_CH];
   logic [DATA_W-1:0]    dac_q   [NUM_CH];
   logic [NUM_CH-1:0]    ldac_q;
   logic [7:0]           err_count_q;
   logic [FRAME_LEN-1:0] frame_data_q;
   logic                 frame_valid_q;
   logic                 frame_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            input_q[ch] <= '0;
            dac_q[ch]   <= '0;
         end
         ldac_q        <= '0;
         err_count_q   <= '0;
         frame_data_q  <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         if (frame_done) begin
            if (bit_count == CNT_W'(FRAME_LEN)) begin
               frame_valid_q <= 1'b1;
               frame_data_q  <= shift_q;
               case (cmd)
                  CMD_WRITE_INPUT: begin
                     for (int ch = 0; ch < NUM_CH; ch++) begin
                        if (hit[ch]) begin
                           input_q[ch] <= wdata;
                           if (ldac_q[ch]) begin
                              dac_q[ch] <= wdata;
                           end
                        end
                     end
                  end
                  CMD_WRITE_UPDATE: begin
                     for (int ch = 0; ch < NUM_CH; ch++) begin
                        if (hit[ch]) begin
                           input_q[ch] <= wdata;
                           dac_q[ch]   <= wdata;
                        end
                     end
                  end
                  CMD_UPDATE: begin
                     for (int ch = 0; ch < NUM_CH; ch++) begin
                        if (hit[ch]) begin
                           dac_q[ch] <= input_q[ch];
                        end
                     end
                  end
                  CMD_LDAC_SETUP: begin
                     ldac_q <= shift_q[DATA_LO +: NUM_CH];
                  end
                  CMD_SW_RESET: begin
                     for (int ch = 0; ch < NUM_CH; ch++) begin
                        input_q[ch] <= '0;
                        dac_q[ch]   <= '0;
                     end
                     ldac_q <= '0;
                  end
                  default: begin
                  end
               endcase
            end else begin
               frame_err_q <= 1'b1;
               if (err_count_q != 8'hFF) begin
                  err_count_q <= err_count_q + 8'd1;
               end
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_dac_out
      assign dac_out[g*DATA_W +: DATA_W] = dac_q[g];
   end

   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
   assign frame_data  = frame_data_q;
   assign ldac_mask   = ldac_q;
   assign err_count   = err_count_q;

endmodule

// File: tb/tb_spi_dac_frame_receiver.sv
// tb/tb_spi_dac_frame_receiver.sv - directed self-checking bench for spi_dac_frame_receiver
module tb_spi_dac_frame_receiver;

   logic        clk = 1'b0;
   logic        rst;
   logic        spi_sclk;
   logic        spi_mosi;
   logic        spi_cs_n;
   logic        frame_valid;
   logic [23:0] frame_data;
   logic        frame_err;
   logic [3:0]  ldac_mask;
   logic [47:0] dac_out;
   logic [7:0]  err_count;

   int compared   = 0;
   int mismatched = 0;
   int n_valid    = 0;
   int n_err      = 0;

   logic pre_p, v_p, e_p, post_p;
   int   nv0, ne0;

   always #5 clk = ~clk;

   spi_dac_frame_receiver dut (
      .clk        (clk),
      .rst        (rst),
      .spi_sclk   (spi_sclk),
      .spi_mosi   (spi_mosi),
      .spi_cs_n   (spi_cs_n),
      .frame_valid(frame_valid),
      .frame_data (frame_data),
      .frame_err  (frame_err),
      .ldac_mask  (ldac_mask),
      .dac_out    (dac_out),
      .err_count  (err_count)
   );

   always @(negedge clk) begin
      if (frame_valid === 1'b1) n_valid++;
      if (frame_err === 1'b1) n_err++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_low();
      @(negedge clk);
      spi_cs_n = 1'b0;
      wait_clk(3);
   endtask

   task automatic shift_bit(input logic b);
      spi_mosi = b;
      wait_clk(3);
      spi_sclk = 1'b1;
      wait_clk(3);
      spi_sclk = 1'b0;
   endtask

   // raises CS (optionally together with a stray sclk rise) and samples the
   // response one cycle before, at, and one cycle after the expected pulse
   task automatic end_frame(input bit stray, output logic pre, output logic v,
                            output logic e, output logic post);
      wait_clk(3);
      spi_cs_n = 1'b1;
      if (stray) spi_sclk = 1'b1;
      wait_clk(3);
      pre = frame_valid | frame_err;
      wait_clk(1);
      v = frame_valid;
      e = frame_err;
      wait_clk(1);
      post = frame_valid | frame_err;
      spi_sclk = 1'b0;
      wait_clk(4);
   endtask

   task automatic send_frame(input logic [31:0] bits, input int nbits, input bit stray,
                             output logic pre, output logic v, output logic e,
                             output logic post);
      cs_low();
      for (int i = nbits - 1; i >= 0; i--) shift_bit(bits[i]);
      end_frame(stray, pre, v, e, post);
   endtask

   initial begin
      rst      = 1'b1;
      spi_sclk = 1'b0;
      spi_mosi = 1'b0;
      spi_cs_n = 1'b1;
      wait_clk(4);
      rst = 1'b0;
      wait_clk(4);
      chk("reset dac_out", dac_out, 0);
      chk("reset err_count", err_count, 0);
      chk("reset ldac_mask", ldac_mask, 0);
      chk("reset frame_data", frame_data, 0);
      chk("reset pulses", {frame_valid, frame_err}, 0);

      send_frame(32'h300ABC, 24, 0, pre_p, v_p, e_p, post_p);
      chk("wu ch0 pulse before latency", pre_p, 0);
      chk("wu ch0 pulse at latency", {v_p, e_p}, 2'b10);
      chk("wu ch0 pulse one cycle", post_p, 0);
      chk("wu ch0 frame_data", frame_data, 24'h300ABC);
      chk("wu ch0 dac_out", dac_out, 48'h000000_0000AB);

      send_frame(32'h600002, 24, 0, pre_p, v_p, e_p, post_p);
      chk("ldac setup mask", ldac_mask, 4'b0010);
      send_frame(32'h210550, 24, 0, pre_p, v_p, e_p, post_p);
      chk("wi ch1 direct", dac_out, 48'h000000_0550AB);
      send_frame(32'h220770, 24, 0, pre_p, v_p, e_p, post_p);
      chk("wi ch2 held", dac_out, 48'h000000_0550AB);
      send_frame(32'h120000, 24, 0, pre_p, v_p, e_p, post_p);
      chk("update ch2 valid", v_p, 1'b1);
      chk("update ch2 dac_out", dac_out, 48'h000077_0550AB);

      send_frame(32'h155555, 23, 0, pre_p, v_p, e_p, post_p);
      chk("short frame pulses", {pre_p, v_p, e_p, post_p}, 4'b0010);
      chk("short err_count", err_count, 1);
      send_frame(32'h1F0FFF0, 25, 0, pre_p, v_p, e_p, post_p);
      chk("long frame pulses", {v_p, e_p}, 2'b01);
      chk("err_count two", err_count, 2);
      chk("err frame_data kept", frame_data, 24'h120000);
      chk("err dac_out kept", dac_out, 48'h000077_0550AB);

      send_frame(32'h3FFFF0, 24, 0, pre_p, v_p, e_p, post_p);
      chk("broadcast dac_out", dac_out, 48'hFFFFFF_FFFFFF);
      send_frame(32'h700000, 24, 0, pre_p, v_p, e_p, post_p);
      chk("sw reset dac_out", dac_out, 0);
      chk("sw reset ldac_mask", ldac_mask, 0);
      chk("sw reset err_count kept", err_count, 2);
      chk("sw reset frame_data", frame_data, 24'h700000);

      send_frame(32'h330120, 24, 1, pre_p, v_p, e_p, post_p);
      chk("stray edge accepted", {v_p, e_p}, 2'b10);
      chk("stray edge dac_out ch3", dac_out, 48'h012000_000000);

      nv0 = n_valid;
      ne0 = n_err;
      cs_low();
      for (int i = 23; i >= 14; i--) shift_bit(1'b1);
      @(negedge clk);
      rst = 1'b1;
      wait_clk(2);
      rst = 1'b0;
      for (int i = 13; i >= 0; i--) shift_bit(1'b0);
      end_frame(0, pre_p, v_p, e_p, post_p);
      wait_clk(6);
      chk("mid-frame rst no valid", n_valid - nv0, 0);
      chk("mid-frame rst no err", n_err - ne0, 0);
      chk("mid-frame rst err_count", err_count, 0);
      chk("mid-frame rst dac_out", dac_out, 0);

      send_frame(32'h320AAA, 24, 0, pre_p, v_p, e_p, post_p);
      chk("post rst frame pulse", {v_p, e_p}, 2'b10);
      chk("post rst frame_data", frame_data, 24'h320AAA);
      chk("post rst dac_out ch2", dac_out, 48'h0000AA_000000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
